// File: rtl/pixel_fb_writer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pixel_pkg
// Purpose  : Shared types, default screen constants and the clip helper for
//            the pixel framebuffer writer.
// Contents : fb_state_t   - writer FSM states (IDLE/RUN/DRAIN/FIN)
//            SCREEN_W_DEF - default screen width
//            SCREEN_H_DEF - default screen height
//            in_bounds()  - full 32-bit signed on-screen test
// Revision : 1.0 - initial release
// ============================================================================
package pixel_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } fb_state_t;

    localparam int SCREEN_W_DEF = 64;
    localparam int SCREEN_H_DEF = 48;

    // Signed compare on all 32 bits so that negative coordinates and very
    // large ones cannot alias onto the screen.
    function automatic logic in_bounds(input logic signed [31:0] x,
                                       input logic signed [31:0] y,
                                       input int                 w,
                                       input int                 h);
        return (x >= 0) && (x < w) && (y >= 0) && (y < h);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pixel_fb_writer_if.sv
`default_nettype none
// ============================================================================
// Module   : pixel_fb_writer_if
// Purpose  : Coordinate stream (valid/ready) plus framebuffer write bus.
// Signals  : _in0/_in1      - signed x/y coordinate
//            _in_valid      - coordinate present
//            _in_ready      - writer can accept a coordinate
//            mem_we         - write request
//            mem_addr       - write address
//            mem_data       - write data (colour)
//            mem_ready      - memory accepts the write this cycle
// Modports : slave  - the framebuffer writer
//            master - the environment (coordinate source + memory)
// Revision : 1.0 - initial release
// ============================================================================
interface pixel_fb_writer_if #(
    parameter int ADDR_W  = 12,
    parameter int COLOR_W = 8
);
    logic signed [31:0]  _in0;
    logic signed [31:0]  _in1;
    logic                _in_valid;
    logic                _in_ready;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [COLOR_W-1:0]  mem_data;
    logic                mem_ready;

    modport slave (
        input  _in0, _in1, _in_valid, mem_ready,
        output _in_ready, mem_we, mem_addr, mem_data
    );

    modport master (
        output _in0, _in1, _in_valid, mem_ready,
        input  _in_ready, mem_we, mem_addr, mem_data
    );
endinterface
`default_nettype wire

// File: rtl/pixel_fb_writer_fifo.sv
`default_nettype none
// ============================================================================
// Module   : pixel_addr_fifo
// Purpose  : Synchronous show-ahead FIFO; the head entry is visible on dout_o
//            whenever the FIFO is not empty (dout_o reads 0 when empty).
// Ports    : _clock, _reset  - clock, synchronous active-high reset
//            flush_i         - empty the FIFO
//            push_i, din_i   - write an entry (ignored when full)
//            pop_i           - drop the head entry (ignored when empty)
//            dout_o          - head entry
//            full_o, empty_o - status flags
//            count_o         - registered occupancy
// Revision : 1.0 - initial release
// ============================================================================
module pixel_addr_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  wire logic             _clock,
    input  wire logic             _reset,
    input  wire logic             flush_i,
    input  wire logic             push_i,
    input  wire logic [WIDTH-1:0] din_i,
    input  wire logic             pop_i,
    output logic      [WIDTH-1:0] dout_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic      [PTR_W:0]   count_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             push_w;
    logic             pop_w;

    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign push_w  = push_i & ~full_o;
    assign pop_w   = pop_i & ~empty_o;
    assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    // Storage needs no reset; emptiness is tracked by the pointers/count.
    always_ff @(posedge _clock) begin
        if (push_w) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge _clock) begin
        if (_reset || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_w) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_w)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_w, pop_w})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: rtl/pixel_fb_writer.sv
`default_nettype none
// ============================================================================
// Module   : pixel_fb_writer
// Purpose  : Consumes an (x, y) coordinate stream, drops off-screen points,
//            buffers linear addresses in a FIFO and issues colour writes to a
//            single-port framebuffer. Pulses _done once the source is done and
//            every buffered write has been accepted.
// Ports    : _clock, _reset - clock, synchronous active-high reset
//            _start, color  - job start pulse and job colour
//            _src_done      - source finished (level or pulse)
//            bus            - coordinate stream + memory write bus (slave)
//            _done          - one-cycle completion pulse
//            pix_count      - pixels written in the current/last job
//            clip_count     - coordinates dropped (PIXEL_FB_WRITER_STATS_EN)
// Options  : PIXEL_FB_WRITER_STATS_EN - build the clip counter and its port
// Revision : 1.0 - initial release
// ============================================================================
module pixel_fb_writer
    import pixel_pkg::*;
#(
    parameter int SCREEN_W   = SCREEN_W_DEF,
    parameter int SCREEN_H   = SCREEN_H_DEF,
    parameter int ADDR_W     = 12,
    parameter int COLOR_W    = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  wire logic               _clock,
    input  wire logic               _reset,
    input  wire logic               _start,
    input  wire logic [COLOR_W-1:0] color,
    input  wire logic               _src_done,
    pixel_fb_writer_if.slave        bus,
    output logic                    _done,
    output logic [15:0]             pix_count
`ifdef PIXEL_FB_WRITER_STATS_EN
    ,
    output logic [15:0]             clip_count
`endif
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    fb_state_t          state_q;
    logic [COLOR_W-1:0] color_q;
    logic [15:0]        pix_count_q;
    logic               done_q;

    logic               accept_w;
    logic               in_bounds_w;
    logic               push_w;
    logic               pop_w;
    logic               flush_w;
    logic [ADDR_W-1:0]  addr_w;
    logic [ADDR_W-1:0]  head_w;
    logic               full_w;
    logic               empty_w;
    logic [CNT_W-1:0]   count_w;

    assign bus._in_ready = (state_q == RUN) & ~full_w;
    assign accept_w      = bus._in_valid & bus._in_ready;
    assign in_bounds_w   = in_bounds(bus._in0, bus._in1, SCREEN_W, SCREEN_H);
    // Address formed at 32 bits, then truncated to the framebuffer width.
    assign addr_w        = ADDR_W'(bus._in1 * SCREEN_W + bus._in0);
    assign push_w        = accept_w & in_bounds_w;
    assign pop_w         = bus.mem_we & bus.mem_ready;
    assign flush_w       = (state_q == IDLE) & _start;

    assign bus.mem_we    = ~empty_w;
    assign bus.mem_addr  = head_w;
    assign bus.mem_data  = color_q;
    assign _done         = done_q;
    assign pix_count     = pix_count_q;

    pixel_addr_fifo #(
        .WIDTH (ADDR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        ._clock  (_clock),
        ._reset  (_reset),
        .flush_i (flush_w),
        .push_i  (push_w),
        .din_i   (addr_w),
        .pop_i   (pop_w),
        .dout_o  (head_w),
        .full_o  (full_w),
        .empty_o (empty_w),
        .count_o (count_w)
    );

    always_ff @(posedge _clock) begin
        if (_reset) begin
            state_q     <= IDLE;
            color_q     <= '0;
            pix_count_q <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (pop_w && pix_count_q != 16'hFFFF) begin
                pix_count_q <= pix_count_q + 16'd1;
            end
            case (state_q)
                IDLE: begin
                    if (_start) begin
                        state_q     <= RUN;
                        color_q     <= color;
                        pix_count_q <= '0;
                    end
                end
                RUN: begin
                    // A coordinate accepted this same cycle is still pushed.
                    if (_src_done) state_q <= DRAIN;
                end
                DRAIN: begin
                    // Zero occupancy also means no write request is pending.
                    if (count_w == '0) begin
                        state_q <= FIN;
                        done_q  <= 1'b1;
                    end
                end
                FIN:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef PIXEL_FB_WRITER_STATS_EN
    logic [15:0] clip_count_q;
    assign clip_count = clip_count_q;

    always_ff @(posedge _clock) begin
        if (_reset) begin
            clip_count_q <= '0;
        end else if (flush_w) begin
            clip_count_q <= '0;
        end else if (accept_w && !in_bounds_w && clip_count_q != 16'hFFFF) begin
            clip_count_q <= clip_count_q + 16'd1;
        end
    end
`endif
endmodule
`default_nettype wire

// File: tb/tb_pixel_fb_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pixel_fb_writer
// Purpose  : Directed self-checking bench for pixel_fb_writer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pixel_fb_writer;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  color;
    logic        src_done;
    logic        done;
    logic [15:0] pix_count;
`ifdef PIXEL_FB_WRITER_STATS_EN
    logic [15:0] clip_count;
`endif

    int checks = 0;
    int errors = 0;

    logic [11:0] addr_q[$];
    logic [7:0]  data_q[$];
    int          done_cnt = 0;

    always #5 clk = ~clk;

    pixel_fb_writer_if #(.ADDR_W(12), .COLOR_W(8)) bus ();

    pixel_fb_writer #(
        .SCREEN_W   (64),
        .SCREEN_H   (48),
        .ADDR_W     (12),
        .COLOR_W    (8),
        .FIFO_DEPTH (4)
    ) dut (
        ._clock    (clk),
        ._reset    (rst),
        ._start    (start),
        .color     (color),
        ._src_done (src_done),
        .bus       (bus),
        ._done     (done),
        .pix_count (pix_count)
`ifdef PIXEL_FB_WRITER_STATS_EN
        ,
        .clip_count(clip_count)
`endif
    );

    // Memory-side monitor: record every accepted write and every done pulse.
    always @(posedge clk) begin
        if (rst === 1'b0 && bus.mem_we === 1'b1 && bus.mem_ready === 1'b1) begin
            addr_q.push_back(bus.mem_addr);
            data_q.push_back(bus.mem_data);
        end
        if (done === 1'b1) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_job(input logic [7:0] c);
        start = 1'b1;
        color = c;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Present a coordinate and return at the negedge after it was accepted.
    task automatic send(input int x, input int y);
        int n;
        n = 0;
        bus._in0      = x;
        bus._in1      = y;
        bus._in_valid = 1'b1;
        while (bus._in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("send_accept", 32'(n < 100), 32'd1);
        @(negedge clk);
    endtask

    task automatic pulse_src_done();
        bus._in_valid = 1'b0;
        src_done      = 1'b1;
        @(negedge clk);
        src_done      = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(done === 1'b1), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        int w0, d0, bad;
        rst           = 1'b1;
        start         = 1'b0;
        color         = 8'h00;
        src_done      = 1'b0;
        bus._in0      = 0;
        bus._in1      = 0;
        bus._in_valid = 1'b0;
        bus.mem_ready = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_in_ready", 32'(bus._in_ready), 32'd0);
        chk("rst_mem_we",   32'(bus.mem_we),    32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr),  32'd0);
        chk("rst_mem_data", 32'(bus.mem_data),  32'd0);
        chk("rst_done",     32'(done),          32'd0);
        chk("rst_pix",      32'(pix_count),     32'd0);
`ifdef PIXEL_FB_WRITER_STATS_EN
        chk("rst_clip",     32'(clip_count),    32'd0);
`endif
        rst = 1'b0;
        @(negedge clk);

        // Filled rectangle 7x5 at (23,17), colour A5, memory always ready
        w0 = addr_q.size();
        d0 = done_cnt;
        start_job(8'hA5);
        send(23, 17);
        chk("lat_mem_we",   32'(bus.mem_we),   32'd1);
        chk("lat_mem_addr", 32'(bus.mem_addr), 32'd1111);
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 7; c++) begin
                if (r != 0 || c != 0) send(23 + c, 17 + r);
            end
        end
        pulse_src_done();
        wait_done("rect_done");
        repeat (5) @(negedge clk);
        chk("rect_writes", 32'(addr_q.size() - w0), 32'd35);
        bad = 0;
        for (int i = 0; i < 35 && (w0 + i) < addr_q.size(); i++) begin
            if (addr_q[w0+i] !== 12'((17 + i / 7) * 64 + 23 + i % 7)) bad++;
            if (data_q[w0+i] !== 8'hA5) bad++;
        end
        chk("rect_addr_data_bad", 32'(bad), 32'd0);
        chk("rect_pix",   32'(pix_count),       32'd35);
        chk("rect_dones", 32'(done_cnt - d0),   32'd1);

        // Clipping
        w0 = addr_q.size();
        start_job(8'h3C);
        send(-1, 0);
        send(64, 5);
        send(0, 48);
        send(63, 47);
        send(0, 0);
        pulse_src_done();
        wait_done("clip_done");
        chk("clip_writes", 32'(addr_q.size() - w0), 32'd2);
        if (addr_q.size() >= w0 + 2) begin
            chk("clip_addr0", 32'(addr_q[w0]),   32'd3071);
            chk("clip_addr1", 32'(addr_q[w0+1]), 32'd0);
        end
        chk("clip_pix", 32'(pix_count), 32'd2);
`ifdef PIXEL_FB_WRITER_STATS_EN
        chk("clip_count", 32'(clip_count), 32'd3);
`endif

        // Backpressure: 20 pixels, memory stalled while the FIFO fills
        w0 = addr_q.size();
        bus.mem_ready = 1'b0;
        start_job(8'h42);
        for (int i = 0; i < 4; i++) send(3 * i, 10);
        chk("bp_in_ready_low", 32'(bus._in_ready), 32'd0);
        chk("bp_mem_we",       32'(bus.mem_we),    32'd1);
        chk("bp_head",         32'(bus.mem_addr),  32'd640);
        repeat (5) @(negedge clk);
        chk("bp_in_ready_still_low", 32'(bus._in_ready), 32'd0);
        bus.mem_ready = 1'b1;
        for (int i = 4; i < 20; i++) send(3 * i, 10);
        pulse_src_done();
        wait_done("bp_done");
        chk("bp_writes", 32'(addr_q.size() - w0), 32'd20);
        bad = 0;
        for (int i = 0; i < 20 && (w0 + i) < addr_q.size(); i++) begin
            if (addr_q[w0+i] !== 12'(640 + 3 * i)) bad++;
        end
        chk("bp_order_bad", 32'(bad), 32'd0);
        chk("bp_pix", 32'(pix_count), 32'd20);

        // Reset in DRAIN with three buffered writes
        bus.mem_ready = 1'b0;
        start_job(8'h99);
        send(1, 1);
        send(2, 1);
        send(3, 1);
        pulse_src_done();
        chk("drain_in_ready", 32'(bus._in_ready), 32'd0);
        chk("drain_mem_we",   32'(bus.mem_we),    32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_mem_we",   32'(bus.mem_we),    32'd0);
        chk("mid_rst_in_ready", 32'(bus._in_ready), 32'd0);
        chk("mid_rst_pix",      32'(pix_count),     32'd0);
        rst = 1'b0;
        bus.mem_ready = 1'b1;
        w0 = addr_q.size();
        d0 = done_cnt;
        repeat (5) @(negedge clk);
        chk("mid_rst_no_writes", 32'(addr_q.size() - w0), 32'd0);
        chk("mid_rst_no_done",   32'(done_cnt - d0),      32'd0);
        start_job(8'h5A);
        send(5, 5);
        pulse_src_done();
        wait_done("after_rst_done");
        repeat (3) @(negedge clk);
        chk("after_rst_writes", 32'(addr_q.size() - w0), 32'd1);
        if (addr_q.size() > w0) begin
            chk("after_rst_addr", 32'(addr_q[w0]), 32'd325);
            chk("after_rst_data", 32'(data_q[w0]), 32'h5A);
        end
        chk("after_rst_dones", 32'(done_cnt - d0), 32'd1);

        // _start while in RUN is ignored
        w0 = addr_q.size();
        start_job(8'h11);
        send(1, 0);
        send(2, 0);
        bus._in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("run_pix_before", 32'(pix_count), 32'd2);
        start_job(8'h77);
        chk("run_still_ready", 32'(bus._in_ready), 32'd1);
        send(3, 0);
        bus._in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("run_pix_no_clear", 32'(pix_count), 32'd3);
        pulse_src_done();
        wait_done("run_done");
        chk("run_writes", 32'(addr_q.size() - w0), 32'd3);
        bad = 0;
        for (int i = w0; i < addr_q.size(); i++) begin
            if (data_q[i] !== 8'h11) bad++;
        end
        chk("run_color_kept_bad", 32'(bad), 32'd0);

        // Empty job: _src_done already high in the first RUN cycle
        repeat (2) @(negedge clk);
        w0 = addr_q.size();
        start    = 1'b1;
        color    = 8'hEE;
        src_done = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("empty_done_c1", 32'(done), 32'd0);
        @(negedge clk);
        chk("empty_done_c2", 32'(done), 32'd0);
        @(negedge clk);
        chk("empty_done_c3", 32'(done), 32'd1);
        src_done = 1'b0;
        @(negedge clk);
        chk("empty_done_c4", 32'(done), 32'd0);
        chk("empty_writes", 32'(addr_q.size() - w0), 32'd0);
        chk("empty_pix",    32'(pix_count),           32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
